// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Instruction-memory loader and store for the 9-bit-instruction core.
// A host streams bytes over a valid/ready port. Each pair of bytes is packed
// into one 9-bit word {hi_byte[0], lo_byte}, and the words are written in order
// into a DEPTH x 9 instruction memory. The core is held in reset until the
// program is complete. After that the memory serves instruction fetch through
// a combinational read port.
//
// Ports:
//   clk        in   1       single clock; all state changes on the rising edge
//   rst        in   1       synchronous active-high reset
//   ld_valid   in   1       host byte valid
//   ld_ready   out  1       loader accepts a byte (decoded from the state register)
//   ld_data    in   8       host byte
//   ld_last    in   1       final byte of the program (sampled on a transfer only)
//   reload     in   1       in DONE, restart loading; ignored elsewhere
//   pc         in   ADDR_W  fetch address
//   inst       out  9       mem[pc], combinational
//   core_rst   out  1       registered datapath reset, low only in DONE
//   done       out  1       registered, high in DONE
//   err        out  1       registered sticky framing/overflow error
//   inst_count out  ADDR_W+1 words written in the current load, 0..DEPTH
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc,
    output logic [8:0]        inst,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   inst_count
);

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,
        LOAD_HI = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] waddr_r;
    logic [ADDR_W-1:0] waddr_s;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_s;
    logic [7:0]        lo_byte_r;
    logic [7:0]        lo_byte_s;
    logic              err_r;
    logic              err_s;
    logic              core_rst_r;
    logic              done_r;
    logic              we_s;
    logic [8:0]        wdata_s;
    logic              xfer_s;

    logic [8:0]        mem [DEPTH];

    assign ld_ready   = (state_r != DONE);
    assign xfer_s     = ld_valid && ld_ready;
    assign core_rst   = core_rst_r;
    assign done       = done_r;
    assign err        = err_r;
    assign inst_count = count_r;

    // Asynchronous read: a same-edge write is seen only after that edge.
    assign inst = mem[pc];

    // Next-state, counter, error and write-strobe decode.
    always_comb begin
        state_s   = state_r;
        waddr_s   = waddr_r;
        count_s   = count_r;
        lo_byte_s = lo_byte_r;
        err_s     = err_r;
        we_s      = 1'b0;
        wdata_s   = {ld_data[0], lo_byte_r};

        case (state_r)
            LOAD_LO: begin
                if (xfer_s) begin
                    if (ld_last) begin
                        // Odd byte count: drop the byte, flag framing error.
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        lo_byte_s = ld_data;
                        state_s   = LOAD_HI;
                    end
                end else begin
                    state_s = LOAD_LO;
                end
            end

            LOAD_HI: begin
                if (xfer_s) begin
                    we_s    = 1'b1;
                    waddr_s = waddr_r + ADDR_ONE;
                    count_s = count_r + COUNT_ONE;
                    if (ld_last) begin
                        state_s = DONE;
                    end else if (waddr_r == LAST_ADDR) begin
                        // Memory filled without a terminator.
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = LOAD_LO;
                    end
                end else begin
                    state_s = LOAD_HI;
                end
            end

            DONE: begin
                if (reload) begin
                    state_s = LOAD_LO;
                    waddr_s = '0;
                    count_s = '0;
                    err_s   = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end

            default: begin
                // Unreachable encoding: recover into a fresh load.
                state_s = LOAD_LO;
                waddr_s = '0;
                count_s = '0;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LOAD_LO;
            waddr_r    <= '0;
            count_r    <= '0;
            lo_byte_r  <= 8'h00;
            err_r      <= 1'b0;
            core_rst_r <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            waddr_r    <= waddr_s;
            count_r    <= count_s;
            lo_byte_r  <= lo_byte_s;
            err_r      <= err_s;
            core_rst_r <= (state_s != DONE);
            done_r     <= (state_s == DONE);
        end
    end

    // Instruction memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem[waddr_r] <= wdata_s;
        end
    end

endmodule
